// File: rtl/clkgen_pkg.sv
// Shared constants and types for the multi-channel clock/tick generator.
// Optional SYNC phase-align feature is enabled by defining CLKGEN_SYNC_EN.
package clkgen_pkg;

    localparam int          CNT_W_DEF     = 32;
    localparam int          CH_IDX_W      = 4;
    localparam int          MAX_CH        = 16;
    localparam int unsigned RESET_DIV_DEF = 25_000_000;

    typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/clkgen_chan.sv
// One generator channel: half-period counter, active/pending divisor, square output and rise tick.
// The sync input is tied low by the top unless CLKGEN_SYNC_EN is defined.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(RESET_DIV_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] div,
    output logic             ck,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] next_div;
    logic             stopped;
    logic             terminal;

    always_comb begin
        stopped  = !en || (div_act == '0);
        terminal = !stopped && (cnt == div_act - ONE);
        // A write landing on the apply cycle supersedes the stored pending value.
        next_div = wr ? div : div_pend;
    end

    // NOTE: all state updates are non-blocking so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            ck       <= 1'b0;
            tick     <= 1'b0;
            pend     <= 1'b0;
            div_act  <= RESET_DIV;
            div_pend <= RESET_DIV;
        end else if (sync) begin
            cnt  <= '0;
            ck   <= 1'b0;
            tick <= 1'b0;
            if (wr) div_pend <= div;
            if (wr || pend) begin
                div_act <= next_div;
                pend    <= 1'b0;
            end
        end else begin
            if (wr) div_pend <= div;
            if (stopped) begin
                cnt  <= '0;
                ck   <= 1'b0;
                tick <= 1'b0;
                if (wr) begin
                    pend <= 1'b1;
                end else if (pend) begin
                    div_act <= div_pend;
                    pend    <= 1'b0;
                end
            end else if (terminal) begin
                cnt  <= '0;
                ck   <= ~ck;
                tick <= ~ck;
                if (wr || pend) begin
                    div_act <= next_div;
                    pend    <= 1'b0;
                end
            end else begin
                cnt  <= cnt + ONE;
                tick <= 1'b0;
                if (wr) pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// NUM_CH independent programmable clock/tick channels with a shared divisor write port.
// Define CLKGEN_SYNC_EN to add the SYNC phase-align input.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = CNT_W_DEF,
    parameter int unsigned RESET_DIV = RESET_DIV_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_CH-1:0]   CH_EN,
    input  logic                CFG_WR,
    input  logic [CH_IDX_W-1:0] CFG_CH,
    input  logic [CNT_W-1:0]    CFG_DIV,
`ifdef CLKGEN_SYNC_EN
    input  logic                SYNC,
`endif
    output logic [NUM_CH-1:0]   CK_OUT,
    output logic [NUM_CH-1:0]   TICK,
    output logic [NUM_CH-1:0]   PEND
);

    logic sync_int;

`ifdef CLKGEN_SYNC_EN
    assign sync_int = SYNC;
`else
    assign sync_int = 1'b0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic wr_ch;

        // Out-of-range channel indices match no instance and are dropped.
        assign wr_ch = CFG_WR && (CFG_CH == CH_IDX_W'(ch));

        clkgen_chan #(
            .CNT_W     (CNT_W),
            .RESET_DIV (CNT_W'(RESET_DIV))
        ) u_chan (
            .clk  (CLK),
            .reset(RESET),
            .en   (CH_EN[ch]),
            .sync (sync_int),
            .wr   (wr_ch),
            .div  (CFG_DIV),
            .ck   (CK_OUT[ch]),
            .tick (TICK[ch]),
            .pend (PEND[ch])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi: directed literal checks plus randomized traffic
// compared every cycle against an edge-scheduled model. Honours CLKGEN_SYNC_EN.
module tb_clkgen_multi;
    import clkgen_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int RST_DIV = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_CH-1:0]   ch_en;
    logic                cfg_wr;
    logic [CH_IDX_W-1:0] cfg_ch;
    div_t                cfg_div;
    logic                sync;
    logic [NUM_CH-1:0]   ck_out, tick, pend;

    int    vectors     = 0;
    int    miscompares = 0;
    longint cyc        = 0;

    // Model: each running channel knows the absolute edge of its next toggle.
    bit     m_run  [NUM_CH];
    longint m_due  [NUM_CH];
    div_t   m_d    [NUM_CH];
    div_t   m_p    [NUM_CH];
    bit     m_pend [NUM_CH];
    bit     m_lvl  [NUM_CH];
    bit     m_tick [NUM_CH];

    clkgen_multi #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W_DEF),
        .RESET_DIV(RST_DIV)
    ) dut (
        .CLK    (clk),
        .RESET  (rst),
        .CH_EN  (ch_en),
        .CFG_WR (cfg_wr),
        .CFG_CH (cfg_ch),
        .CFG_DIV(cfg_div),
`ifdef CLKGEN_SYNC_EN
        .SYNC   (sync),
`endif
        .CK_OUT (ck_out),
        .TICK   (tick),
        .PEND   (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit   wr;
            div_t nd;
            wr = cfg_wr && (int'(cfg_ch) == ch);
            if (rst) begin
                m_run[ch] = 0; m_lvl[ch] = 0; m_tick[ch] = 0; m_pend[ch] = 0;
                m_d[ch] = RST_DIV; m_p[ch] = RST_DIV;
            end else if (sync) begin
                m_run[ch] = 0; m_lvl[ch] = 0; m_tick[ch] = 0;
                if (wr) begin
                    m_d[ch] = cfg_div; m_p[ch] = cfg_div; m_pend[ch] = 0;
                end else if (m_pend[ch]) begin
                    m_d[ch] = m_p[ch]; m_pend[ch] = 0;
                end
            end else if (!ch_en[ch] || m_d[ch] == 0) begin
                m_run[ch] = 0; m_lvl[ch] = 0; m_tick[ch] = 0;
                if (wr) begin
                    m_p[ch] = cfg_div; m_pend[ch] = 1;
                end else if (m_pend[ch]) begin
                    m_d[ch] = m_p[ch]; m_pend[ch] = 0;
                end
            end else begin
                if (!m_run[ch]) begin
                    m_run[ch] = 1;
                    m_due[ch] = cyc + longint'(m_d[ch]) - 1;
                end
                if (cyc == m_due[ch]) begin
                    m_lvl[ch]  = !m_lvl[ch];
                    m_tick[ch] = m_lvl[ch];
                    nd = wr ? cfg_div : (m_pend[ch] ? m_p[ch] : m_d[ch]);
                    if (wr) m_p[ch] = cfg_div;
                    m_pend[ch] = 0;
                    m_d[ch]    = nd;
                    m_due[ch]  = cyc + longint'(nd);
                end else begin
                    m_tick[ch] = 0;
                    if (wr) begin
                        m_p[ch] = cfg_div; m_pend[ch] = 1;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        logic [3*NUM_CH-1:0] exp;
        @(posedge clk);
        model_edge();
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp[2*NUM_CH+ch] = m_lvl[ch];
            exp[NUM_CH+ch]   = m_tick[ch];
            exp[ch]          = m_pend[ch];
        end
        check($sformatf("model_cyc%0d", cyc), {ck_out, tick, pend}, exp);
    endtask

    task automatic write(input int ch, input int unsigned d);
        cfg_wr = 1'b1; cfg_ch = CH_IDX_W'(ch); cfg_div = div_t'(d);
        step();
        cfg_wr = 1'b0;
    endtask

    initial begin
        logic [15:0] ck_hist, tk_hist;
        logic [11:0] ck1_hist, pd1_hist;
        rst = 1'b1; ch_en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("reset_ck", ck_out, 0);
        check("reset_tick", tick, 0);
        check("reset_pend", pend, 0);

        write(7, 3);
        check("bad_ch_pend", pend, 0);

        write(0, 4);
        check("pend_set", pend[0], 1);
        step();
        check("pend_applied", pend[0], 0);

        // Enable ch0 with D=4: rise after 4th edge, period 8.
        ch_en[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            ck_hist[15-i] = ck_out[0];
            tk_hist[15-i] = tick[0];
        end
        check("ch0_ck_pattern", ck_hist, 16'b0001111000011110);
        check("ch0_tick_pattern", tk_hist, 16'b0001000000010000);

        repeat (4) step();
        check("ch0_high_before_drop", ck_out[0], 1);
        ch_en[0] = 1'b0;
        step();
        check("ch0_drop_ck", ck_out[0], 0);
        check("ch0_drop_tick", tick[0], 0);
        ch_en[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            ck_hist[3-i] = ck_out[0];
        end
        check("ch0_reenable_rise", ck_hist[3:0], 4'b0001);

        // ch1: D=10 running, retarget to D=3 mid half-period.
        write(1, 10);
        step();
        ch_en[1] = 1'b1;
        repeat (14) step();
        write(1, 3);
        check("ch1_pend_mid", pend[1], 1);
        for (int i = 0; i < 12; i++) begin
            step();
            ck1_hist[11-i] = ck_out[1];
            pd1_hist[11-i] = pend[1];
        end
        check("ch1_ck_pattern", ck1_hist, 12'b111100011100);
        check("ch1_pend_pattern", pd1_hist, 12'b111100000000);

        // ch2: stop with D=0, then restart with D=2.
        write(2, 2);
        step();
        ch_en[2] = 1'b1;
        repeat (5) step();
        write(2, 0);
        repeat (6) step();
        check("ch2_stopped_ck", ck_out[2], 0);
        check("ch2_stopped_tick", tick[2], 0);
        write(2, 2);
        step();
        check("ch2_restart_pend", pend[2], 0);
        repeat (6) step();

`ifdef CLKGEN_SYNC_EN
        ch_en = '0;
        step();
        write(0, 5);
        write(1, 5);
        step();
        ch_en[0] = 1'b1;
        repeat (2) step();
        ch_en[1] = 1'b1;
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            ck_hist[5-i]  = ck_out[0];
            ck1_hist[5-i] = ck_out[1];
        end
        check("sync_ch0", ck_hist[5:0], 6'b000011);
        check("sync_ch1", ck1_hist[5:0], 6'b000011);
        rst = 1'b1; sync = 1'b1; cfg_wr = 1'b1; cfg_ch = '0; cfg_div = 9;
        step();
        rst = 1'b0; sync = 1'b0; cfg_wr = 1'b0;
        check("rst_sync_ck", ck_out, 0);
        check("rst_sync_pend", pend, 0);
`endif

        // Randomized traffic, model-checked every cycle.
        ch_en = NUM_CH'($urandom);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) ch_en ^= NUM_CH'(1) << $urandom_range(NUM_CH-1);
            cfg_wr  = ($urandom_range(5) == 0);
            cfg_ch  = CH_IDX_W'($urandom_range(7));
            cfg_div = ($urandom_range(7) == 0) ? '0 : div_t'($urandom_range(9, 1));
            rst     = ($urandom_range(799) == 0);
`ifdef CLKGEN_SYNC_EN
            sync    = ($urandom_range(199) == 0);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
